program_sequencer: RTL and testbench

- Top-level controller that walks a stored program block by block and hands each block to the UPDI flash-write engine.
- Pulses `rom_start` on the program ROM/decoder, waits for each decoded block, and dispatches DATA blocks as write operations.
- Handles engine errors with bounded retries and a watchdog timeout, then reports completion or failure to the host/UI logic.
- Block data bytes flow directly from the decoder to the engine; this block carries only the control and header fields.

---
 rtl/program_sequencer_pkg.sv | 22 ++
 rtl/program_sequencer_timeout_counter.sv | 26 ++
 rtl/program_sequencer.sv | 153 +++++++++++++++
 tb/tb_program_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg: shared states, block type codes and engine op codes
package program_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_BLK,
        DISPATCH,
        WAIT_ENG,
        VERIFY,
        WAIT_VFY,
        FINISH,
        FAIL
    } seq_state_t;

    localparam logic [7:0] BLK_TYPE_DATA = 8'h00;
    localparam logic [7:0] BLK_TYPE_EOF  = 8'h01;

    localparam logic ENG_OP_WRITE  = 1'b0;
    localparam logic ENG_OP_VERIFY = 1'b1;

endpackage

// File: rtl/program_sequencer_timeout_counter.sv
// timeout_counter: watchdog that flags the last cycle of a TIMEOUT_CYCLES window
module timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    assign expired = enable && (count == LAST);

    // count while enabled, parking on the last value until cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else if (clear) count <= '0;
        else if (enable && !expired) count <= count + W'(1);
    end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: walks decoded program blocks and dispatches DATA blocks to the flash engine
// Optional read-back verify after each write: define PROGRAM_SEQUENCER_VERIFY_EN
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int MAX_RETRIES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int BLOCK_CNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      go,
    output logic                      busy,
    output logic                      finished,
    output logic                      failed,
    output logic [BLOCK_CNT_BITS-1:0] blocks_done,
    output logic                      rom_start,
    input  logic                      rom_ready,
    input  logic                      rom_done,
    input  logic [7:0]                blk_length,
    input  logic [15:0]               blk_address,
    input  logic [7:0]                blk_type,
    output logic                      eng_req,
    output logic                      eng_op,
    output logic [15:0]               eng_address,
    output logic [7:0]                eng_length,
    input  logic                      eng_ack,
    input  logic                      eng_done,
    input  logic                      eng_error
);

    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [BLOCK_CNT_BITS-1:0] CNT_ONE = BLOCK_CNT_BITS'(1);

    seq_state_t                state;
    logic [RW-1:0]             retries;
    logic                      started;
    logic                      expired;
    logic                      done_ok;
    logic                      attempt_bad;
    logic                      can_retry;
    logic [BLOCK_CNT_BITS-1:0] blocks_next;

    assign busy        = !(state inside {IDLE, FINISH, FAIL});
    assign finished    = state == FINISH;
    assign failed      = state == FAIL;
    assign rom_start   = (state == FETCH) && rom_ready;
    assign done_ok     = eng_done && !eng_error;
    assign attempt_bad = eng_done || expired;
    assign can_retry   = retries < RETRY_MAX;
    assign blocks_next = &blocks_done ? blocks_done : blocks_done + CNT_ONE;

`ifdef PROGRAM_SEQUENCER_VERIFY_EN
    assign eng_op = (state == VERIFY) ? ENG_OP_VERIFY : ENG_OP_WRITE;
`else
    assign eng_op = ENG_OP_WRITE;
`endif

    timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state == DISPATCH) || (state == VERIFY)),
        .enable  ((state == WAIT_ENG) || (state == WAIT_VFY)),
        .expired (expired)
    );

    // block-walking FSM with registered request, header copy and block counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            retries     <= '0;
            started     <= 1'b0;
            eng_req     <= 1'b0;
            eng_address <= '0;
            eng_length  <= '0;
            blocks_done <= '0;
        end else begin
            started <= rom_start;
            case (state)
                IDLE, FINISH, FAIL: begin
                    if (go) begin
                        state       <= FETCH;
                        blocks_done <= '0;
                        retries     <= '0;
                    end
                end
                FETCH: begin
                    if (rom_ready) state <= WAIT_BLK;
                end
                WAIT_BLK: begin
                    if (!started && rom_ready) begin
                        if (rom_done || blk_type == BLK_TYPE_EOF) begin
                            state <= FINISH;
                        end else if (blk_type == BLK_TYPE_DATA && blk_length != 8'd0) begin
                            state       <= DISPATCH;
                            eng_req     <= 1'b1;
                            eng_address <= blk_address;
                            eng_length  <= blk_length;
                            retries     <= '0;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DISPATCH: begin
                    if (eng_ack) begin
                        state   <= WAIT_ENG;
                        eng_req <= 1'b0;
                    end
                end
                WAIT_ENG: begin
                    if (done_ok) begin
`ifdef PROGRAM_SEQUENCER_VERIFY_EN
                        state   <= VERIFY;
                        eng_req <= 1'b1;
`else
                        state       <= FETCH;
                        blocks_done <= blocks_next;
`endif
                    end else if (attempt_bad) begin
                        state   <= can_retry ? DISPATCH : FAIL;
                        eng_req <= can_retry;
                        if (can_retry) retries <= retries + RW'(1);
                    end
                end
`ifdef PROGRAM_SEQUENCER_VERIFY_EN
                VERIFY: begin
                    if (eng_ack) begin
                        state   <= WAIT_VFY;
                        eng_req <= 1'b0;
                    end
                end
                WAIT_VFY: begin
                    if (done_ok) begin
                        state       <= FETCH;
                        blocks_done <= blocks_next;
                    end else if (attempt_bad) begin
                        state   <= can_retry ? DISPATCH : FAIL;
                        eng_req <= can_retry;
                        if (can_retry) retries <= retries + RW'(1);
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    eng_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: scoreboard bench with decoder and engine models
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    localparam int TO = 20;
    localparam int MR = 2;
`ifdef PROGRAM_SEQUENCER_VERIFY_EN
    localparam int PER_BLK = 2;
`else
    localparam int PER_BLK = 1;
`endif

    typedef struct packed {
        logic        op;
        logic [15:0] addr;
        logic [7:0]  len;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic        busy, finished, failed, rom_start, eng_req, eng_op;
    logic [15:0] blocks_done, eng_address, blk_address;
    logic [7:0]  eng_length, blk_length, blk_type;
    logic        rom_ready, rom_done, eng_ack, eng_done, eng_error;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_req = 0;
    int   ack_cyc = 0;
    bit   have_ack = 0;
    bit   gap_chk = 0;
    req_t exp_q[$];
    int   resp_q[$];
    logic [7:0]  p_type[16];
    logic [15:0] p_addr[16];
    logic [7:0]  p_len[16];
    int   p_n = 0;
    int   p_i = 0;

    program_sequencer #(
        .MAX_RETRIES    (MR),
        .TIMEOUT_CYCLES (TO),
        .BLOCK_CNT_BITS (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .busy        (busy),
        .finished    (finished),
        .failed      (failed),
        .blocks_done (blocks_done),
        .rom_start   (rom_start),
        .rom_ready   (rom_ready),
        .rom_done    (rom_done),
        .blk_length  (blk_length),
        .blk_address (blk_address),
        .blk_type    (blk_type),
        .eng_req     (eng_req),
        .eng_op      (eng_op),
        .eng_address (eng_address),
        .eng_length  (eng_length),
        .eng_ack     (eng_ack),
        .eng_done    (eng_done),
        .eng_error   (eng_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic new_prog();
        p_n = 0;
        p_i = 0;
        n_req = 0;
        have_ack = 0;
        gap_chk = 0;
        exp_q.delete();
        resp_q.delete();
    endtask

    task automatic add_blk(input logic [7:0] t, input logic [15:0] a, input logic [7:0] l);
        p_type[p_n] = t;
        p_addr[p_n] = a;
        p_len[p_n] = l;
        p_n++;
    endtask

    task automatic expect_req(input logic op, input logic [15:0] a, input logic [7:0] l);
        exp_q.push_back(req_t'{op, a, l});
    endtask

    task automatic expect_data(input logic [15:0] a, input logic [7:0] l);
        expect_req(ENG_OP_WRITE, a, l);
`ifdef PROGRAM_SEQUENCER_VERIFY_EN
        expect_req(ENG_OP_VERIFY, a, l);
`endif
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic start_run(input string tag);
        pulse_go();
        check({tag, "_latency"}, 32'(rom_start), 1);
        check({tag, "_busy"}, 32'(busy), 1);
    endtask

    task automatic wait_req(input int n, input string tag);
        int k = 0;
        while (n_req < n && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 32'(n_req >= n), 1);
    endtask

    task automatic wait_end(input string tag, output int when);
        int k = 0;
        while (!(finished || failed) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        when = cyc;
        check(tag, 32'(finished || failed), 1);
    endtask

    // decoder model: answers each rom_start with the next header after a short decode delay
    initial begin
        rom_ready = 1'b1;
        rom_done = 1'b0;
        blk_type = 8'hFF;
        blk_address = '0;
        blk_length = '0;
        forever begin
            @(negedge clk);
            if (rom_start) begin
                @(posedge clk); #1;
                rom_ready = 1'b0;
                rom_done = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                if (p_i < p_n) begin
                    blk_type = p_type[p_i];
                    blk_address = p_addr[p_i];
                    blk_length = p_len[p_i];
                end else begin
                    rom_done = 1'b1;
                end
                p_i++;
                rom_ready = 1'b1;
            end
        end
    end

    // engine model: checks each request against the scoreboard, acks, then replies per resp_q
    initial begin
        req_t e;
        int r;
        eng_ack = 1'b0;
        eng_done = 1'b0;
        eng_error = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (eng_req) begin
                n_req++;
                if (exp_q.size() == 0) check("req_extra", 32'(exp_q.size()), 1);
                else begin
                    e = exp_q.pop_front();
                    check("req", 32'({eng_op, eng_address, eng_length}), 32'(e));
                end
                if (gap_chk && have_ack) check("timeout_gap", 32'(cyc - ack_cyc), TO);
                @(posedge clk); #1 eng_ack = 1'b1;
                @(posedge clk); #1;
                eng_ack = 1'b0;
                ack_cyc = cyc;
                have_ack = 1;
                r = (resp_q.size() != 0) ? resp_q.pop_front() : 0;
                if (r != 2) begin
                    repeat (9) @(posedge clk);
                    #1;
                    eng_done = 1'b1;
                    eng_error = (r == 1);
                    @(posedge clk); #1;
                    eng_done = 1'b0;
                    eng_error = 1'b0;
                end
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", 32'({busy, finished, failed, rom_start, eng_req, eng_op}), 0);
        check("reset_cnt", 32'(blocks_done), 0);
        check("reset_hdr", 32'({eng_address, eng_length}), 0);
        rst = 1'b1;

        new_prog();
        for (int i = 0; i < 3; i++) begin
            add_blk(BLK_TYPE_DATA, 16'h8000 + 16'(i * 64), 8'd64);
            expect_data(16'h8000 + 16'(i * 64), 8'd64);
        end
        start_run("nominal");
        wait_req(2, "nominal_req2");
        pulse_go();
        wait_end("nominal_end", t);
        check("nominal_reqs", n_req, 3 * PER_BLK);
        check("nominal_sb", 32'(exp_q.size()), 0);
        check("nominal_blocks", 32'(blocks_done), 3);
        check("nominal_flags", 32'({busy, finished, failed}), 3'b010);
        repeat (5) @(posedge clk);
        #1 check("finish_hold", 32'({finished, busy}), 2'b10);

        new_prog();
        add_blk(8'h05, 16'h1000, 8'd10);
        add_blk(BLK_TYPE_DATA, 16'h2000, 8'd0);
        add_blk(BLK_TYPE_EOF, 16'h0000, 8'd0);
        add_blk(BLK_TYPE_DATA, 16'h7000, 8'd8);
        start_run("skip");
        wait_end("skip_end", t);
        check("skip_reqs", n_req, 0);
        check("skip_blocks", 32'(blocks_done), 0);
        check("skip_fetches", p_i, 3);
        check("skip_flags", 32'({finished, failed}), 2'b10);

        new_prog();
        add_blk(BLK_TYPE_DATA, 16'h1230, 8'd16);
        expect_req(ENG_OP_WRITE, 16'h1230, 8'd16);
        expect_data(16'h1230, 8'd16);
        resp_q.push_back(1);
        for (int i = 0; i < PER_BLK; i++) resp_q.push_back(0);
        start_run("retry");
        wait_end("retry_end", t);
        check("retry_reqs", n_req, 1 + PER_BLK);
        check("retry_blocks", 32'(blocks_done), 1);
        check("retry_flags", 32'({finished, failed}), 2'b10);

        new_prog();
        add_blk(BLK_TYPE_DATA, 16'h4000, 8'd32);
        for (int i = 0; i < 3; i++) begin
            expect_req(ENG_OP_WRITE, 16'h4000, 8'd32);
            resp_q.push_back(2);
        end
        gap_chk = 1;
        start_run("tmo");
        wait_end("tmo_end", t);
        check("tmo_fail_gap", t - ack_cyc, TO);
        check("tmo_reqs", n_req, 3);
        check("tmo_flags", 32'({busy, finished, failed}), 3'b001);
        check("tmo_blocks", 32'(blocks_done), 0);
        gap_chk = 0;

        new_prog();
        add_blk(BLK_TYPE_DATA, 16'h6000, 8'd4);
        add_blk(BLK_TYPE_DATA, 16'h6100, 8'd4);
        expect_data(16'h6000, 8'd4);
        expect_req(ENG_OP_WRITE, 16'h6100, 8'd4);
        for (int i = 0; i < PER_BLK; i++) resp_q.push_back(0);
        resp_q.push_back(2);
        start_run("rstrun");
        wait_req(PER_BLK + 1, "rst_req");
        for (int k = 0; k < 10 && eng_req; k++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1 check("rst_pre", 32'({busy, blocks_done}), 32'h10001);
        #2 rst = 1'b0;
        #1;
        check("rst_flags", 32'({busy, finished, failed, rom_start, eng_req}), 0);
        check("rst_cnt", 32'(blocks_done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        new_prog();
        add_blk(BLK_TYPE_DATA, 16'h9000, 8'd8);
        expect_data(16'h9000, 8'd8);
        start_run("restart");
        wait_end("restart_end", t);
        check("restart_blocks", 32'(blocks_done), 1);
        check("restart_flags", 32'({finished, failed}), 2'b10);

`ifdef PROGRAM_SEQUENCER_VERIFY_EN
        new_prog();
        add_blk(BLK_TYPE_DATA, 16'h5000, 8'd4);
        expect_req(ENG_OP_WRITE, 16'h5000, 8'd4);
        expect_req(ENG_OP_VERIFY, 16'h5000, 8'd4);
        expect_req(ENG_OP_WRITE, 16'h5000, 8'd4);
        expect_req(ENG_OP_VERIFY, 16'h5000, 8'd4);
        resp_q.push_back(0);
        resp_q.push_back(1);
        resp_q.push_back(0);
        resp_q.push_back(0);
        start_run("vfy");
        wait_req(4, "vfy_req4");
        check("vfy_blocks_mid", 32'(blocks_done), 0);
        wait_end("vfy_end", t);
        check("vfy_reqs", n_req, 4);
        check("vfy_blocks", 32'(blocks_done), 1);
        check("vfy_flags", 32'({finished, failed}), 2'b10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
